xup_debounce5: RTL and testbench
================================

# xup_debounce5

Five-channel synchronizer and debouncer for the Basys3 pushbuttons (btnC, btnU, btnL, btnR, btnD). It sits directly upstream of the five-input gate primitives in the lab library. It turns raw, asynchronous, bouncing button levels into clean, clock-domain-safe levels that feed gate inputs a–e. Per-channel one-cycle rise/fall pulses are also produced for downstream counters and FSMs.

## Interface
- DEBOUNCE_COUNT, 1_000_000: consecutive stable cycles required before an output changes (10 ms at 100 MHz); legal range 2 to 2^CNT_W−1.
- CNT_W, 20: width of each per-channel stability counter.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on rising clk edge.
- btn_in  input  5  raw button levels, asynchronous to clk; bit 0=C, 1=U, 2=L, 3=R, 4=D.
- btn_db  output  5  debounced levels; connect to gate inputs a..e.
- btn_rise  output  5  one-cycle pulse when the matching btn_db bit goes 0→1.
- btn_fall  output  5  one-cycle pulse when the matching btn_db bit goes 1→0.

## Operation
- The five channels are fully independent and identical.
- Synchronizer: a 2-flop chain per bit. sync[i] is btn_in[i] delayed by 2 clk edges. No logic sits between the two flops.
- Stability counter cnt[i], CNT_W bits:
  - If sync[i] == btn_db[i]: cnt[i] <= 0.
  - If sync[i] != btn_db[i] and cnt[i] < DEBOUNCE_COUNT−1: cnt[i] <= cnt[i]+1.
  - If sync[i] != btn_db[i] and cnt[i] == DEBOUNCE_COUNT−1: btn_db[i] <= sync[i] and cnt[i] <= 0.
- Bounce handling: any single cycle where sync[i] equals btn_db[i] clears the count, so a glitch shorter than DEBOUNCE_COUNT cycles never reaches btn_db.
- Counter never wraps. The terminal compare is an equality at DEBOUNCE_COUNT−1, so cnt[i] never exceeds that value.
- Pulses are registered:
  - btn_rise[i] is 1 for exactly the cycle in which btn_db[i] first reads 1 after being 0.
  - btn_fall[i] is the same for 1→0.
  - Both are 0 in all other cycles. rise and fall are never both high on one bit.
- Simultaneous events: several channels may change or pulse in the same cycle. There is no arbitration.
- Reset (any cycle, including mid-count):
  - Sync flops, cnt, btn_db, btn_rise and btn_fall all go to 0 on the next edge.
  - In-progress counts are discarded.
  - A button held during reset is seen as a fresh press after release of reset and produces a rise pulse.

## Timing
- Reset values: btn_db=5'b0, btn_rise=5'b0, btn_fall=5'b0.
- Latency, with btn_in stable from the edge at which it is first sampled (edge 0):
  - sync changes at edge 2.
  - btn_db and the matching pulse change at edge 2+DEBOUNCE_COUNT.
- Pulse width: exactly 1 clk cycle.
- Minimum stable input duration to propagate: DEBOUNCE_COUNT cycles at the sync output.
- Combinational paths: none from input to output. All outputs come straight from flops.

## Structure
- Shared package xup_basys3_pkg holds:
  - the button index constants BTN_C=0, BTN_U=1, BTN_L=2, BTN_R=3, BTN_D=4;
  - the default DEBOUNCE_COUNT for a 100 MHz clock.
- Sub-module xup_debounce_ch: one channel (2-flop synchronizer, counter, db flop, rise/fall flops), parameterized by DEBOUNCE_COUNT and CNT_W.
- Top level: five instances of xup_debounce_ch plus port concatenation. No other logic.

## Test plan
All scenarios use DEBOUNCE_COUNT=4, CNT_W=3.
- Clean press: after reset, set btn_in=5'b00001 and hold → btn_db[0] rises at edge 6 (2+4). btn_rise=5'b00001 for that single cycle. Other bits stay 0.
- Bounce reject: on bit 2, toggle 1 for 3 cycles, 0 for 1 cycle, repeated 5 times → btn_db[2] stays 0 and btn_rise[2] never asserts. Then hold 1 → rise occurs 6 edges after the hold starts.
- Release: with btn_db=5'b10000, drop btn_in[4] to 0 and hold → btn_fall[4] pulses once at edge 6. btn_db returns to 0.
- Simultaneous: btn_in goes from 5'b00000 to 5'b11111 on one edge → btn_db becomes 5'b11111 and btn_rise=5'b11111 together in one cycle. The next cycle btn_rise=0.
- Reset mid-count: press bit 1, assert reset when the counter reads 2, keep the button held, release reset → btn_db[1] stays 0 for 5 edges after reset deasserts, rises at edge 6, and emits one btn_rise[1] pulse.
- Reset values: assert reset with btn_in=5'b11111 → all outputs read 0 on the next edge and stay 0 while reset is held.

Source files
------------

// File: rtl/xup_basys3_pkg.sv
// Shared Basys3 constants: pushbutton bit positions
// and the debounce length used at a 100 MHz clock.
package xup_basys3_pkg;

   localparam int unsigned BTN_C = 0;
   localparam int unsigned BTN_U = 1;
   localparam int unsigned BTN_L = 2;
   localparam int unsigned BTN_R = 3;
   localparam int unsigned BTN_D = 4;

   localparam int unsigned NUM_BTN = 5;

   // 10 ms of stability at 100 MHz.
   localparam int unsigned DEBOUNCE_100MHZ = 1_000_000;

endpackage

// File: rtl/xup_debounce_ch.sv
// One button channel: 2-flop synchronizer, stability counter,
// debounced level and registered rise/fall pulses.
module xup_debounce_ch #(
   parameter int unsigned DEBOUNCE_COUNT = 1_000_000,
   parameter int unsigned CNT_W          = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_db,
   output logic btn_rise,
   output logic btn_fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             db_q;
   logic             db_d;
   logic             rise_q;
   logic             rise_d;
   logic             fall_q;
   logic             fall_d;

   // Synchronizer chain: plain flop-to-flop, nothing in between.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive disagreeing cycles; commit on the last one.
   always_comb begin
      cnt_d  = cnt_q;
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync2_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d  = '0;
         db_d   = sync2_q;
         rise_d = sync2_q;
         fall_d = ~sync2_q;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Counter, debounced level and edge pulses update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         db_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         db_q   <= db_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign btn_db   = db_q;
   assign btn_rise = rise_q;
   assign btn_fall = fall_q;

endmodule

// File: rtl/xup_debounce5.sv
// Five independent debounce channels for the Basys3 buttons;
// bit order C, U, L, R, D feeds gate inputs a..e.
module xup_debounce5
   import xup_basys3_pkg::*;
#(
   parameter int unsigned DEBOUNCE_COUNT = DEBOUNCE_100MHZ,
   parameter int unsigned CNT_W          = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] btn_in,
   output logic [4:0] btn_db,
   output logic [4:0] btn_rise,
   output logic [4:0] btn_fall
);

   xup_debounce_ch #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT),
      .CNT_W         (CNT_W)
   ) u_ch_c (
      .clk     (clk),
      .reset   (reset),
      .btn_in  (btn_in[BTN_C]),
      .btn_db  (btn_db[BTN_C]),
      .btn_rise(btn_rise[BTN_C]),
      .btn_fall(btn_fall[BTN_C])
   );

   xup_debounce_ch #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT),
      .CNT_W         (CNT_W)
   ) u_ch_u (
      .clk     (clk),
      .reset   (reset),
      .btn_in  (btn_in[BTN_U]),
      .btn_db  (btn_db[BTN_U]),
      .btn_rise(btn_rise[BTN_U]),
      .btn_fall(btn_fall[BTN_U])
   );

   xup_debounce_ch #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT),
      .CNT_W         (CNT_W)
   ) u_ch_l (
      .clk     (clk),
      .reset   (reset),
      .btn_in  (btn_in[BTN_L]),
      .btn_db  (btn_db[BTN_L]),
      .btn_rise(btn_rise[BTN_L]),
      .btn_fall(btn_fall[BTN_L])
   );

   xup_debounce_ch #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT),
      .CNT_W         (CNT_W)
   ) u_ch_r (
      .clk     (clk),
      .reset   (reset),
      .btn_in  (btn_in[BTN_R]),
      .btn_db  (btn_db[BTN_R]),
      .btn_rise(btn_rise[BTN_R]),
      .btn_fall(btn_fall[BTN_R])
   );

   xup_debounce_ch #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT),
      .CNT_W         (CNT_W)
   ) u_ch_d (
      .clk     (clk),
      .reset   (reset),
      .btn_in  (btn_in[BTN_D]),
      .btn_db  (btn_db[BTN_D]),
      .btn_rise(btn_rise[BTN_D]),
      .btn_fall(btn_fall[BTN_D])
   );

endmodule

// File: tb/tb_xup_debounce5.sv
// Bench for xup_debounce5 with DEBOUNCE_COUNT=4, CNT_W=3.
// Edge t=0 is the edge after which the stimulus is applied.
module tb_xup_debounce5;

   localparam int unsigned DC = 4;
   localparam int unsigned LAT = 2 + DC;

   typedef struct {
      logic [4:0] db;
      logic [4:0] rise;
      logic [4:0] fall;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] btn_in = 5'b0;
   logic [4:0] btn_db;
   logic [4:0] btn_rise;
   logic [4:0] btn_fall;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   xup_debounce5 #(
      .DEBOUNCE_COUNT(DC),
      .CNT_W         (3)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .btn_in  (btn_in),
      .btn_db  (btn_db),
      .btn_rise(btn_rise),
      .btn_fall(btn_fall)
   );

   always #5 clk = ~clk;

   // Stimulus only: reset with buttons released, leave just after edge.
   task automatic do_reset();
      btn_in = 5'b0;
      reset  = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      btn_in = 5'b0;
      reset  = 1'b1;
      for (int t = 1; t <= 3; t++) begin
         e.db = 5'b0; e.rise = 5'b0; e.fall = 5'b0;
         exp_q.push_back(e);
      end
      for (int t = 1; t <= 3; t++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks += 3;
         if (btn_db !== e.db) begin
            errors++;
            $display("FAIL reset db t=%0d got %b want %b", t, btn_db, e.db);
         end
         if (btn_rise !== e.rise) begin
            errors++;
            $display("FAIL reset rise t=%0d got %b want %b", t, btn_rise, e.rise);
         end
         if (btn_fall !== e.fall) begin
            errors++;
            $display("FAIL reset fall t=%0d got %b want %b", t, btn_fall, e.fall);
         end
      end
      #1 reset = 1'b0;
   endtask

   task automatic test_clean_press();
      exp_t e;
      do_reset();
      btn_in = 5'b00001;
      for (int t = 1; t <= 8; t++) begin
         e.db   = (t >= LAT) ? 5'b00001 : 5'b0;
         e.rise = (t == LAT) ? 5'b00001 : 5'b0;
         e.fall = 5'b0;
         exp_q.push_back(e);
      end
      for (int t = 1; t <= 8; t++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks += 3;
         if (btn_db !== e.db) begin
            errors++;
            $display("FAIL press db t=%0d got %b want %b", t, btn_db, e.db);
         end
         if (btn_rise !== e.rise) begin
            errors++;
            $display("FAIL press rise t=%0d got %b want %b", t, btn_rise, e.rise);
         end
         if (btn_fall !== e.fall) begin
            errors++;
            $display("FAIL press fall t=%0d got %b want %b", t, btn_fall, e.fall);
         end
      end
   endtask

   task automatic test_bounce();
      exp_t e;
      do_reset();
      btn_in = 5'b00100;
      for (int t = 1; t <= 28; t++) begin
         e.db   = (t >= 20 + LAT) ? 5'b00100 : 5'b0;
         e.rise = (t == 20 + LAT) ? 5'b00100 : 5'b0;
         e.fall = 5'b0;
         exp_q.push_back(e);
      end
      for (int t = 1; t <= 28; t++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks += 3;
         if (btn_db !== e.db) begin
            errors++;
            $display("FAIL bounce db t=%0d got %b want %b", t, btn_db, e.db);
         end
         if (btn_rise !== e.rise) begin
            errors++;
            $display("FAIL bounce rise t=%0d got %b want %b", t, btn_rise, e.rise);
         end
         if (btn_fall !== e.fall) begin
            errors++;
            $display("FAIL bounce fall t=%0d got %b want %b", t, btn_fall, e.fall);
         end
         if (t < 20) btn_in[2] = ((t % 4) < 3);
         else        btn_in[2] = 1'b1;
      end
   endtask

   task automatic test_release();
      exp_t e;
      do_reset();
      btn_in = 5'b10000;
      for (int t = 1; t <= 16; t++) begin
         e.db   = (t >= LAT && t < 8 + LAT) ? 5'b10000 : 5'b0;
         e.rise = (t == LAT) ? 5'b10000 : 5'b0;
         e.fall = (t == 8 + LAT) ? 5'b10000 : 5'b0;
         exp_q.push_back(e);
      end
      for (int t = 1; t <= 16; t++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks += 3;
         if (btn_db !== e.db) begin
            errors++;
            $display("FAIL release db t=%0d got %b want %b", t, btn_db, e.db);
         end
         if (btn_rise !== e.rise) begin
            errors++;
            $display("FAIL release rise t=%0d got %b want %b", t, btn_rise, e.rise);
         end
         if (btn_fall !== e.fall) begin
            errors++;
            $display("FAIL release fall t=%0d got %b want %b", t, btn_fall, e.fall);
         end
         if (t == 8) btn_in = 5'b0;
      end
   endtask

   task automatic test_simultaneous();
      exp_t e;
      do_reset();
      btn_in = 5'b11111;
      for (int t = 1; t <= 8; t++) begin
         e.db   = (t >= LAT) ? 5'b11111 : 5'b0;
         e.rise = (t == LAT) ? 5'b11111 : 5'b0;
         e.fall = 5'b0;
         exp_q.push_back(e);
      end
      for (int t = 1; t <= 8; t++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks += 3;
         if (btn_db !== e.db) begin
            errors++;
            $display("FAIL simul db t=%0d got %b want %b", t, btn_db, e.db);
         end
         if (btn_rise !== e.rise) begin
            errors++;
            $display("FAIL simul rise t=%0d got %b want %b", t, btn_rise, e.rise);
         end
         if (btn_fall !== e.fall) begin
            errors++;
            $display("FAIL simul fall t=%0d got %b want %b", t, btn_fall, e.fall);
         end
      end
   endtask

   // Starts with all buttons held and debounced high.
   task automatic test_reset_values();
      exp_t e;
      btn_in = 5'b11111;
      reset  = 1'b1;
      for (int t = 1; t <= 11; t++) begin
         e.db   = (t >= 4 + LAT) ? 5'b11111 : 5'b0;
         e.rise = (t == 4 + LAT) ? 5'b11111 : 5'b0;
         e.fall = 5'b0;
         exp_q.push_back(e);
      end
      for (int t = 1; t <= 11; t++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks += 3;
         if (btn_db !== e.db) begin
            errors++;
            $display("FAIL rstval db t=%0d got %b want %b", t, btn_db, e.db);
         end
         if (btn_rise !== e.rise) begin
            errors++;
            $display("FAIL rstval rise t=%0d got %b want %b", t, btn_rise, e.rise);
         end
         if (btn_fall !== e.fall) begin
            errors++;
            $display("FAIL rstval fall t=%0d got %b want %b", t, btn_fall, e.fall);
         end
         if (t == 4) reset = 1'b0;
      end
   endtask

   // Reset lands after edge 4, when channel 1 has counted to 2.
   task automatic test_reset_mid_count();
      exp_t e;
      do_reset();
      btn_in = 5'b00010;
      for (int t = 1; t <= 14; t++) begin
         e.db   = (t >= 6 + LAT) ? 5'b00010 : 5'b0;
         e.rise = (t == 6 + LAT) ? 5'b00010 : 5'b0;
         e.fall = 5'b0;
         exp_q.push_back(e);
      end
      for (int t = 1; t <= 14; t++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks += 3;
         if (btn_db !== e.db) begin
            errors++;
            $display("FAIL midrst db t=%0d got %b want %b", t, btn_db, e.db);
         end
         if (btn_rise !== e.rise) begin
            errors++;
            $display("FAIL midrst rise t=%0d got %b want %b", t, btn_rise, e.rise);
         end
         if (btn_fall !== e.fall) begin
            errors++;
            $display("FAIL midrst fall t=%0d got %b want %b", t, btn_fall, e.fall);
         end
         if (t == 4) reset = 1'b1;
         if (t == 6) reset = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release();
      test_simultaneous();
      test_reset_values();
      test_reset_mid_count();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard leftover got %0d want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
